ext_resize_pipe: RTL and testbench

//  Multi-channel, parametrised resize stage. Sign- or zero-extends each N_IN-bit sample, applies a runtime

---
 rtl/ext_resize_pipe_pkg.sv | 36 +++
 rtl/ext_resize_pipe_lane.sv | 78 +++++++
 rtl/ext_resize_pipe.sv | 129 ++++++++++++
 tb/tb_ext_resize_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ext_resize_pipe_pkg.sv
// ============================================================================
// Module : ext_resize_pipe_pkg
// Brief  : Shared constants, mode encodings and helpers for the resize pipeline
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ext_resize_pipe_pkg;

  localparam int DEF_N_IN   = 16;
  localparam int DEF_N_OUT  = 31;
  localparam int DEF_CH     = 1;
  localparam int DEF_SH_MAX = 16;

  localparam int W_INT      = DEF_N_IN + DEF_SH_MAX;
  localparam int SH_W       = $clog2(DEF_SH_MAX + 1);
  localparam int OVF_CNT_W  = 16;

  localparam logic SGN_UNSIGNED = 1'b0;
  localparam logic SGN_SIGNED   = 1'b1;

  function automatic int w_int_of(input int n_in, input int sh_max);
    return n_in + sh_max;
  endfunction

  function automatic int sh_w_of(input int sh_max);
    return $clog2(sh_max + 1);
  endfunction

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_resize_pipe_lane.sv
// ============================================================================
// Module : ext_resize_lane
// Brief  : Per-channel combinational extend+shift and range-check/clamp logic
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_resize_lane
  import ext_resize_pipe_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SH_MAX = DEF_SH_MAX,
  localparam int c_w_int = N_IN + SH_MAX,
  localparam int c_sh_w  = $clog2(SH_MAX + 1)
) (
  input  logic [N_IN-1:0]    i_sample,
  input  logic               i_s1_sgn,
  input  logic [c_sh_w-1:0]  i_shift,
  output logic [c_w_int-1:0] o_scaled,
  input  logic [c_w_int-1:0] i_scaled,
  input  logic               i_s2_sgn,
  input  logic               i_s2_sat,
  output logic [N_OUT-1:0]   o_result,
  output logic               o_ovf
);

  localparam logic [c_sh_w-1:0] c_sh_max = c_sh_w'(SH_MAX);

  logic [c_w_int-1:0] w_ext;
  logic [c_sh_w-1:0]  w_sh;

  assign w_sh = (i_shift > c_sh_max) ? c_sh_max : i_shift;

  // W_INT has SH_MAX bits of headroom, so the shift never loses bits
  always_comb begin
    w_ext = ((i_s1_sgn == SGN_SIGNED) && i_sample[N_IN-1]) ? '1 : '0;
    w_ext[N_IN-1:0] = i_sample;
    o_scaled = w_ext << w_sh;
  end

  if (c_w_int <= N_OUT) begin : g_widen
    logic w_unused_sat;
    assign w_unused_sat = i_s2_sat;

    always_comb begin
      o_result = ((i_s2_sgn == SGN_SIGNED) && i_scaled[c_w_int-1]) ? '1 : '0;
      o_result[c_w_int-1:0] = i_scaled;
      o_ovf = 1'b0;
    end
  end else begin : g_narrow
    logic w_signed;
    logic w_fit;

    assign w_signed = (i_s2_sgn == SGN_SIGNED);

    // Signed fits when all bits from N_OUT-1 upward agree; unsigned when they are zero above N_OUT-1
    always_comb begin
      if (w_signed) begin
        w_fit = (&i_scaled[c_w_int-1:N_OUT-1]) || !(|i_scaled[c_w_int-1:N_OUT-1]);
      end else begin
        w_fit = !(|i_scaled[c_w_int-1:N_OUT]);
      end
      o_ovf = !w_fit;
      if (w_fit || !i_s2_sat) begin
        o_result = i_scaled[N_OUT-1:0];
      end else if (w_signed) begin
        o_result = i_scaled[c_w_int-1] ? {1'b1, {(N_OUT-1){1'b0}}}
                                       : {1'b0, {(N_OUT-1){1'b1}}};
      end else begin
        o_result = '1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ext_resize_pipe.sv
// ============================================================================
// Module : ext_resize_pipe
// Brief  : Two-stage valid/ready multi-channel sign/zero extend, scale, resize
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ext_resize_pipe
  import ext_resize_pipe_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int CH     = DEF_CH,
  parameter int SH_MAX = DEF_SH_MAX
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [CH*N_IN-1:0]           IN_DATA,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic                         MODE_SGN,
  input  logic                         SAT_EN,
  input  logic [sh_w_of(SH_MAX)-1:0]   SHIFT,
  output logic [CH*N_OUT-1:0]          OUT_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [CH-1:0]                OUT_OVF,
  output logic                         OVF_STICKY,
  output logic [OVF_CNT_W-1:0]         OVF_CNT,
  input  logic                         CLR_OVF
);

  localparam int c_w_int = w_int_of(N_IN, SH_MAX);

  logic                    r_s1_vld;
  logic                    r_s1_sgn;
  logic                    r_s1_sat;
  logic [CH*c_w_int-1:0]   r_s1_data;
  logic [CH*c_w_int-1:0]   w_s1_data;

  logic                    r_s2_vld;
  logic [CH*N_OUT-1:0]     r_s2_data;
  logic [CH-1:0]           r_s2_ovf;
  logic [CH*N_OUT-1:0]     w_s2_data;
  logic [CH-1:0]           w_s2_ovf;

  logic                    r_ovf_sticky;
  logic [OVF_CNT_W-1:0]    r_ovf_cnt;

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    w_ovf_xfer;

  assign w_s2_adv   = !r_s2_vld || OUT_READY;
  assign w_s1_adv   = !r_s1_vld || w_s2_adv;
  assign IN_READY   = RST_N && w_s1_adv;
  assign w_ovf_xfer = r_s2_vld && OUT_READY && (|r_s2_ovf);

  for (genvar g = 0; g < CH; g++) begin : g_lane
    ext_resize_lane #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .SH_MAX (SH_MAX)
    ) u_lane (
      .i_sample (IN_DATA[g*N_IN +: N_IN]),
      .i_s1_sgn (MODE_SGN),
      .i_shift  (SHIFT),
      .o_scaled (w_s1_data[g*c_w_int +: c_w_int]),
      .i_scaled (r_s1_data[g*c_w_int +: c_w_int]),
      .i_s2_sgn (r_s1_sgn),
      .i_s2_sat (r_s1_sat),
      .o_result (w_s2_data[g*N_OUT +: N_OUT]),
      .o_ovf    (w_s2_ovf[g])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_vld  <= 1'b0;
      r_s1_sgn  <= 1'b0;
      r_s1_sat  <= 1'b0;
      r_s1_data <= '0;
    end else if (w_s1_adv) begin
      r_s1_vld <= IN_VALID;
      if (IN_VALID) begin
        r_s1_sgn  <= MODE_SGN;
        r_s1_sat  <= SAT_EN;
        r_s1_data <= w_s1_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_ovf  <= '0;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_data <= w_s2_data;
        r_s2_ovf  <= w_s2_ovf;
      end
    end
  end

  // An overflow transfer takes priority over a concurrent clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end else if (w_ovf_xfer) begin
      r_ovf_sticky <= 1'b1;
      r_ovf_cnt    <= CLR_OVF ? OVF_CNT_W'(1) : sat_inc(r_ovf_cnt);
    end else if (CLR_OVF) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_cnt    <= '0;
    end
  end

  assign OUT_DATA   = r_s2_data;
  assign OUT_VALID  = r_s2_vld;
  assign OUT_OVF    = r_s2_ovf;
  assign OVF_STICKY = r_ovf_sticky;
  assign OVF_CNT    = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ext_resize_pipe.sv
// ============================================================================
// Module : tb_ext_resize_pipe
// Brief  : Directed self-checking bench for ext_resize_pipe (CH=1 and CH=4)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ext_resize_pipe;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic [15:0]  in_data;
  logic         in_valid, in_ready;
  logic         mode_sgn, sat_en;
  logic [4:0]   shift;
  logic [30:0]  out_data;
  logic         out_valid, out_ready;
  logic [0:0]   out_ovf;
  logic         ovf_sticky;
  logic [15:0]  ovf_cnt;
  logic         clr_ovf;

  logic [63:0]  in4;
  logic         iv4, ir4, ov4, st4;
  logic [123:0] out4;
  logic [3:0]   ovf4;
  logic [15:0]  cnt4;

  ext_resize_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE_SGN(mode_sgn), .SAT_EN(sat_en), .SHIFT(shift), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_OVF(out_ovf),
    .OVF_STICKY(ovf_sticky), .OVF_CNT(ovf_cnt), .CLR_OVF(clr_ovf)
  );

  ext_resize_pipe #(.CH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(in4), .IN_VALID(iv4), .IN_READY(ir4),
    .MODE_SGN(mode_sgn), .SAT_EN(sat_en), .SHIFT(shift), .OUT_DATA(out4),
    .OUT_VALID(ov4), .OUT_READY(out_ready), .OUT_OVF(ovf4),
    .OVF_STICKY(st4), .OVF_CNT(cnt4), .CLR_OVF(clr_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int sent, rcv, occ;
  logic in_fire, out_fire;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One beat through an empty pipe; controls are scrambled after accept
  task automatic beat(input string tag, input logic sgn, input logic sat, input logic [4:0] sh,
                      input logic [15:0] din, input logic [30:0] exp_d, input logic exp_o,
                      input logic clr_with);
    mode_sgn = sgn; sat_en = sat; shift = sh; in_data = din; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_inrdy"}, 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0; mode_sgn = ~sgn; sat_en = ~sat; shift = 5'd0; in_data = ~din;
    chk({tag, "_lat1"}, 128'(out_valid), 128'(1'b0));
    tick();
    chk({tag, "_vld"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_data"}, 128'(out_data), 128'(exp_d));
    chk({tag, "_ovf"}, 128'(out_ovf), 128'(exp_o));
    clr_ovf = clr_with;
    tick();
    clr_ovf = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; in_data = '0; in_valid = 1'b0; mode_sgn = 1'b1; sat_en = 1'b1;
    shift = '0; out_ready = 1'b1; clr_ovf = 1'b0; in4 = '0; iv4 = 1'b0;
    #1;
    chk("rst_inrdy", 128'(in_ready), 128'(1'b0));
    chk("rst_outvld", 128'(out_valid), 128'(1'b0));
    chk("rst_cnt", 128'(ovf_cnt), 128'(16'd0));
    chk("rst_sticky", 128'(ovf_sticky), 128'(1'b0));
    tick(); tick();
    RST_N = 1'b1;
    #1;
    chk("post_rst_inrdy", 128'(in_ready), 128'(1'b1));

    // Basic extend, clamp of oversized shift, saturation and wrap
    beat("sgn8000", 1'b1, 1'b1, 5'd0, 16'h8000, 31'h7FFF8000, 1'b0, 1'b0);
    beat("uns8000", 1'b0, 1'b1, 5'd0, 16'h8000, 31'h00008000, 1'b0, 1'b0);
    beat("clamp31", 1'b1, 1'b1, 5'd31, 16'h0001, 31'h00010000, 1'b0, 1'b0);
    chk("cnt_none", 128'(ovf_cnt), 128'(16'd0));
    beat("sat7fff", 1'b1, 1'b1, 5'd16, 16'h7FFF, 31'h3FFFFFFF, 1'b1, 1'b0);
    beat("sat8000", 1'b1, 1'b1, 5'd16, 16'h8000, 31'h40000000, 1'b1, 1'b0);
    beat("usatffff", 1'b0, 1'b1, 5'd16, 16'hFFFF, 31'h7FFFFFFF, 1'b1, 1'b0);
    chk("cnt3", 128'(ovf_cnt), 128'(16'd3));
    chk("sticky3", 128'(ovf_sticky), 128'(1'b1));
    beat("wrap7fff", 1'b1, 1'b0, 5'd16, 16'h7FFF, 31'h7FFF0000, 1'b1, 1'b1);
    chk("clr_vs_xfer_cnt", 128'(ovf_cnt), 128'(16'd1));
    chk("clr_vs_xfer_sticky", 128'(ovf_sticky), 128'(1'b1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_cnt", 128'(ovf_cnt), 128'(16'd0));
    chk("clr_sticky", 128'(ovf_sticky), 128'(1'b0));

    // Stream of 8 beats with OUT_READY pattern 1,0,0,1
    mode_sgn = 1'b1; sat_en = 1'b0; shift = 5'd0;
    sent = 0; rcv = 0; occ = 0;
    for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_data   = 16'(sent + 1);
      #1;
      chk("stream_inrdy", 128'(in_ready), 128'(!(occ == 2 && !out_ready)));
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        chk("stream_data", 128'(out_data), 128'(31'(rcv + 1)));
        rcv++;
      end
      if (in_fire) sent++;
      occ = occ + int'(in_fire) - int'(out_fire);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 128'(rcv), 128'(8));
    chk("stream_cnt", 128'(ovf_cnt), 128'(16'd0));

    // Four channels, only channel 2 overflows; ch3 sits exactly at the negative bound
    mode_sgn = 1'b1; sat_en = 1'b1; shift = 5'd16;
    in4 = {16'hC000, 16'h4000, 16'hFFFF, 16'h0001};
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    chk("ch4_vld", 128'(ov4), 128'(1'b1));
    chk("ch4_data", 128'(out4), 128'({31'h40000000, 31'h3FFFFFFF, 31'h7FFF0000, 31'h00010000}));
    chk("ch4_ovf", 128'(ovf4), 128'(4'b0100));
    tick();
    chk("ch4_cnt", 128'(cnt4), 128'(16'd1));

    // Fill both stages under stall, then reset mid-stream
    out_ready = 1'b0; mode_sgn = 1'b1; sat_en = 1'b0; shift = 5'd0;
    in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_inrdy", 128'(in_ready), 128'(1'b0));
    chk("full_outvld", 128'(out_valid), 128'(1'b1));
    chk("full_hold", 128'(out_data), 128'(31'h11));
    RST_N = 1'b0;
    #1;
    chk("midrst_outvld", 128'(out_valid), 128'(1'b0));
    chk("midrst_inrdy", 128'(in_ready), 128'(1'b0));
    tick();
    RST_N = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("flushed", 128'(out_valid), 128'(1'b0));
    beat("after_rst", 1'b1, 1'b0, 5'd4, 16'hFFFF, 31'h7FFFFFF0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
